vga_scanout: RTL and testbench



---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_scanout_if.sv | 10 +
 rtl/vga_timing.sv | 76 +++++++
 rtl/vga_scanout.sv | 127 ++++++++++++
 tb/tb_vga_scanout.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared colour type, framebuffer geometry and default 640x480@60 timing
// for the 160x120 scan-out path.
package vga_pkg;

  typedef logic [2:0] colour_t;

  localparam colour_t BLACK  = 3'b000;
  localparam colour_t BLUE   = 3'b001;
  localparam colour_t GREEN  = 3'b010;
  localparam colour_t YELLOW = 3'b110;
  localparam colour_t RED    = 3'b100;
  localparam colour_t WHITE  = 3'b111;

  localparam int unsigned SCREEN_WIDTH  = 160;
  localparam int unsigned SCREEN_HEIGHT = 120;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  // y*160 + x as shift-and-add; the largest result is 19199.
  function automatic logic [14:0] fb_addr(input logic [7:0] fx, input logic [6:0] fy);
    fb_addr = ({8'd0, fy} << 7) + ({8'd0, fy} << 5) + {7'd0, fx};
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus the once-per-frame vertical-blank pulse.
// master: scan-out side; slave: framebuffer RAM / drawing logic side.
interface vga_scanout_if;
  logic [14:0]     rd_addr;
  vga_pkg::colour_t rd_data;
  logic            frame_done;

  modport master (output rd_addr, output frame_done, input rd_data);
  modport slave  (input rd_addr, input frame_done, output rd_data);
endinterface

// File: rtl/vga_timing.sv
// Pixel clock enable, h/v raster counters, raw sync/visible flags and the
// registered vertical-blank entry pulse.
module vga_timing #(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT_DEF,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC_DEF,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK_DEF,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT_DEF,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC_DEF,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_ce_o,
  output logic [7:0] fx_o,
  output logic [6:0] fy_o,
  output logic       visible_o,
  output logic       hsync_n_o,
  output logic       vsync_n_o,
  output logic       frame_done_o
);

  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_BEG     = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_BEG     = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pix_ce_q, pix_ce_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       frame_done_q, frame_done_d;

  always_comb begin
    pix_ce_d     = ~pix_ce_q;
    h_d          = h_q;
    v_d          = v_q;
    frame_done_d = 1'b0;
    if (pix_ce_q) begin
      if (h_q == H_LAST) begin
        h_d          = '0;
        v_d          = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        frame_done_d = (v_q == V_VIS_LAST);
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_ce_q     <= 1'b0;
      h_q          <= '0;
      v_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pix_ce_q     <= pix_ce_d;
      h_q          <= h_d;
      v_q          <= v_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_ce_o     = pix_ce_q;
  assign fx_o         = h_q[9:2];
  assign fy_o         = v_q[8:2];
  assign visible_o    = (h_q < H_VIS) && (v_q < V_VIS);
  assign hsync_n_o    = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vsync_n_o    = !((v_q >= VS_BEG) && (v_q < VS_END));
  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scan-out: address generation, 4x4 pixel replication and the
// aligned VGA pin register stage. SCANOUT_BORDER_EN forces a white frame border.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  vga_scanout_if.master fb,
  output logic [9:0]    VGA_R,
  output logic [9:0]    VGA_G,
  output logic [9:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK,
  output logic          VGA_SYNC,
  output logic          VGA_CLK
);

  logic       pix_ce, visible, hsync_n, vsync_n;
  logic [7:0] fx;
  logic [6:0] fy;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk         (CLOCK_50),
    .rst         (reset),
    .pix_ce_o    (pix_ce),
    .fx_o        (fx),
    .fy_o        (fy),
    .visible_o   (visible),
    .hsync_n_o   (hsync_n),
    .vsync_n_o   (vsync_n),
    .frame_done_o(fb.frame_done)
  );

  // Stage 1 travels with rd_addr; stage 2 meets rd_data one pixel later.
  logic [14:0] addr_q, addr_d;
  logic        vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  colour_t     rgb_q, rgb_d, pix_colour;
  logic        blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;

`ifdef SCANOUT_BORDER_EN
  logic border1_q, border1_d;
  assign pix_colour = border1_q ? WHITE : fb.rd_data;
`else
  assign pix_colour = fb.rd_data;
`endif

  always_comb begin
    addr_d  = addr_q;
    vis1_d  = vis1_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    rgb_d   = rgb_q;
    blank_d = blank_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
`ifdef SCANOUT_BORDER_EN
    border1_d = border1_q;
`endif
    if (pix_ce) begin
      if (visible) addr_d = fb_addr(fx, fy);
      vis1_d  = visible;
      hs1_d   = hsync_n;
      vs1_d   = vsync_n;
`ifdef SCANOUT_BORDER_EN
      border1_d = (fx == '0) || (fx == 8'(SCREEN_WIDTH - 1)) ||
                  (fy == '0) || (fy == 7'(SCREEN_HEIGHT - 1));
`endif
      rgb_d   = vis1_q ? pix_colour : BLACK;
      blank_d = vis1_q;
      hs_d    = hs1_q;
      vs_d    = vs1_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      addr_q  <= '0;
      vis1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      rgb_q   <= BLACK;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
`ifdef SCANOUT_BORDER_EN
      border1_q <= 1'b0;
`endif
    end else begin
      addr_q  <= addr_d;
      vis1_q  <= vis1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      rgb_q   <= rgb_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
`ifdef SCANOUT_BORDER_EN
      border1_q <= border1_d;
`endif
    end
  end

  assign fb.rd_addr = addr_q;
  assign VGA_R      = {10{rgb_q[2]}};
  assign VGA_G      = {10{rgb_q[1]}};
  assign VGA_B      = {10{rgb_q[0]}};
  assign VGA_HS     = hs_q;
  assign VGA_VS     = vs_q;
  assign VGA_BLANK  = blank_q;
  assign VGA_SYNC   = 1'b0;
  // Pins change on the edge where this falls, so the DAC samples mid-pixel.
  assign VGA_CLK    = pix_ce;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a reduced raster, with a synchronous
// framebuffer RAM model and a raster-position reference model.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int HV = 64, HF = 8, HSY = 16, HB = 8;
  localparam int VV = 32, VF = 3, VSY = 2, VB = 4;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FRAME = 2 * HT * VT;
`ifdef SCANOUT_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] r, g, b;
  logic hs, vs, blank, sync, vclk;

  vga_scanout_if bus ();

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .fb       (bus),
    .VGA_R    (r),
    .VGA_G    (g),
    .VGA_B    (b),
    .VGA_HS   (hs),
    .VGA_VS   (vs),
    .VGA_BLANK(blank),
    .VGA_SYNC (sync),
    .VGA_CLK  (vclk)
  );

  always #10 clk = ~clk;

  logic [2:0] mem [0:19199];
  always @(posedge clk) bus.rd_data <= (bus.rd_addr < 15'd19200) ? mem[bus.rd_addr] : 3'b000;

  int n;
  int tests = 0;
  int fails = 0;
  logic [14:0] exp_addr;

  // Raster position q counts pixel clocks since reset release.
  function automatic bit is_vis(input int q);
    return (q % HT < HV) && ((q / HT) % VT < VV);
  endfunction

  function automatic int pix_addr(input int q);
    return (((q / HT) % VT) / 4) * 160 + (q % HT) / 4;
  endfunction

  function automatic logic [2:0] pix_colour(input int q);
    int fx, fy;
    fx = (q % HT) / 4;
    fy = ((q / HT) % VT) / 4;
    if (BORDER && (fx == 0 || fx == 159 || fy == 0 || fy == 119)) return 3'b111;
    return mem[pix_addr(q)];
  endfunction

  function automatic logic [50:0] expect_pins(input int cyc, input logic [14:0] addr);
    logic [2:0] c;
    logic ehs, evs, ebl, efd, eclk;
    int q, h, v;
    c = 3'b000; ehs = 1'b1; evs = 1'b1; ebl = 1'b0; efd = 1'b0;
    if (cyc >= 4) begin
      q = cyc / 2 - 2;
      h = q % HT;
      v = (q / HT) % VT;
      ehs = !(h >= HV + HF && h < HV + HF + HSY);
      evs = !(v >= VV + VF && v < VV + VF + VSY);
      if (is_vis(q)) begin
        ebl = 1'b1;
        c = pix_colour(q);
      end
    end
    if (cyc >= 2 && cyc % 2 == 0) begin
      q = cyc / 2 - 1;
      efd = (q % HT == HT - 1) && ((q / HT) % VT == VV - 1);
    end
    eclk = (cyc % 2 == 1);
    return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}, ehs, evs, ebl, eclk, 1'b0, efd, addr};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      n = 0;
      exp_addr = '0;
    end else begin
      n++;
      if (n >= 2 && n % 2 == 0 && is_vis(n / 2 - 1)) exp_addr = 15'(pix_addr(n / 2 - 1));
    end
    #1;
  endtask

  task automatic test_reset();
    logic [50:0] act;
    rst = 1'b1;
    for (int i = 0; i < 19200; i++) mem[i] = 3'(i % 8);
    for (int i = 0; i < 3; i++) begin
      step();
      act = {r, g, b, hs, vs, blank, vclk, sync, bus.frame_done, bus.rd_addr};
      tests++;
      if (act !== {30'd0, 6'b110000, 15'd0}) begin
        fails++;
        $display("FAIL reset_state cycle %0d: got %h expected %h", i, act, {30'd0, 6'b110000, 15'd0});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_first_addr();
    while (n < 10) begin
      step();
      if (n == 2 || n == 9) begin
        tests++;
        if (bus.rd_addr !== 15'd0) begin
          fails++;
          $display("FAIL first_addr n=%0d: rd_addr=%0d expected 0", n, bus.rd_addr);
        end
      end
      if (n == 10) begin
        tests++;
        if (bus.rd_addr !== 15'd1) begin
          fails++;
          $display("FAIL second_addr n=%0d: rd_addr=%0d expected 1", n, bus.rd_addr);
        end
      end
    end
  endtask

  task automatic test_sample_pixel();
    int target, ea;
    logic [2:0] c;
    target = 2 * (8 * HT + 20 + 1);
    ea = 2 * 160 + 5;
    c = 3'(ea % 8);
    while (n < target) step();
    tests++;
    if (bus.rd_addr !== 15'(ea)) begin
      fails++;
      $display("FAIL sample_addr: rd_addr=%0d expected %0d", bus.rd_addr, ea);
    end
    step(); step();
    tests++;
    if ({r, g, b} !== {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}}) begin
      fails++;
      $display("FAIL sample_colour: rgb=%h expected %h", {r, g, b}, {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}});
    end
    tests++;
    if (bus.rd_addr !== 15'(ea)) begin
      fails++;
      $display("FAIL sample_addr_hold: rd_addr=%0d expected %0d", bus.rd_addr, ea);
    end
    repeat (6) step();
    tests++;
    if (bus.rd_addr !== 15'(ea + 1)) begin
      fails++;
      $display("FAIL sample_addr_next: rd_addr=%0d expected %0d", bus.rd_addr, ea + 1);
    end
  endtask

  task automatic test_full_frame();
    logic [50:0] act, ex;
    logic p_hs, p_vs, p_bl, p_fd;
    int hs_fall, vs_fall, fd_rise, bl_rise, lines, fd_count, vs_count;
    rst = 1'b1;
    for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom_range(0, 7));
    repeat (3) step();
    rst = 1'b0;
    p_hs = 1'b1; p_vs = 1'b1; p_bl = 1'b0; p_fd = 1'b0;
    hs_fall = -1; vs_fall = -1; fd_rise = -1; bl_rise = -1;
    lines = 0; fd_count = 0; vs_count = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      act = {r, g, b, hs, vs, blank, vclk, sync, bus.frame_done, bus.rd_addr};
      ex = expect_pins(n, exp_addr);
      tests++;
      if (act !== ex) begin
        fails++;
        $display("FAIL pins n=%0d: got %h expected %h", n, act, ex);
      end
      if (!blank) begin
        tests++;
        if ({r, g, b} !== 30'd0) begin
          fails++;
          $display("FAIL rgb_in_blank n=%0d: rgb=%h expected 0", n, {r, g, b});
        end
      end
      if (p_hs && !hs) begin
        if (hs_fall >= 0) begin
          tests++;
          if (n - hs_fall != 2 * HT) begin
            fails++;
            $display("FAIL hs_period: %0d cycles expected %0d", n - hs_fall, 2 * HT);
          end
        end
        hs_fall = n;
      end
      if (!p_hs && hs && hs_fall >= 0) begin
        tests++;
        if (n - hs_fall != 2 * HSY) begin
          fails++;
          $display("FAIL hs_low: %0d cycles expected %0d", n - hs_fall, 2 * HSY);
        end
      end
      if (p_vs && !vs) vs_fall = n;
      if (!p_vs && vs && vs_fall >= 0) begin
        vs_count++;
        tests++;
        if (n - vs_fall != 2 * VSY * HT) begin
          fails++;
          $display("FAIL vs_low: %0d cycles expected %0d", n - vs_fall, 2 * VSY * HT);
        end
      end
      if (!p_bl && blank) bl_rise = n;
      if (p_bl && !blank && bl_rise >= 0) begin
        lines++;
        tests++;
        if (n - bl_rise != 2 * HV) begin
          fails++;
          $display("FAIL blank_width: %0d cycles expected %0d", n - bl_rise, 2 * HV);
        end
      end
      if (p_fd) begin
        tests++;
        if (bus.frame_done !== 1'b0) begin
          fails++;
          $display("FAIL frame_done_width n=%0d: frame_done=%b expected 0", n, bus.frame_done);
        end
      end
      if (!p_fd && bus.frame_done === 1'b1) begin
        fd_count++;
        if (fd_rise >= 0) begin
          tests++;
          if (n - fd_rise != FRAME) begin
            fails++;
            $display("FAIL frame_done_period: %0d cycles expected %0d", n - fd_rise, FRAME);
          end
        end
        fd_rise = n;
      end
      p_hs = hs; p_vs = vs; p_bl = blank; p_fd = bus.frame_done;
    end
    tests++;
    if (lines != 2 * VV) begin
      fails++;
      $display("FAIL visible_lines: %0d expected %0d", lines, 2 * VV);
    end
    tests++;
    if (fd_count != 2 || vs_count != 2) begin
      fails++;
      $display("FAIL frame_events: frame_done=%0d vs=%0d expected 2 and 2", fd_count, vs_count);
    end
  endtask

`ifdef SCANOUT_BORDER_EN
  task automatic test_border();
    logic [50:0] act, ex;
    int q, h, v;
    rst = 1'b1;
    for (int i = 0; i < 19200; i++) mem[i] = BLACK;
    repeat (3) step();
    rst = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      act = {r, g, b, hs, vs, blank, vclk, sync, bus.frame_done, bus.rd_addr};
      ex = expect_pins(n, exp_addr);
      tests++;
      if (act !== ex) begin
        fails++;
        $display("FAIL border_pins n=%0d: got %h expected %h", n, act, ex);
      end
      if (n >= 4 && n % 2 == 0) begin
        q = n / 2 - 2;
        h = q % HT;
        v = (q / HT) % VT;
        if ((h == 0 && v == 8) || (h == 40 && v == 0)) begin
          tests++;
          if ({r, g, b} !== {30{1'b1}}) begin
            fails++;
            $display("FAIL border_white h=%0d v=%0d: rgb=%h expected all ones", h, v, {r, g, b});
          end
        end
        if (h == 32 && v == 16) begin
          tests++;
          if ({r, g, b} !== 30'd0) begin
            fails++;
            $display("FAIL border_interior: rgb=%h expected 0", {r, g, b});
          end
        end
      end
    end
  endtask
`endif

  task automatic test_midframe_reset();
    logic [50:0] act;
    int guard, k;
    guard = 0;
    while (!(n >= 2 && n % 2 == 0 && ((n / 2 - 1) / HT) % VT == 20) && guard < FRAME) begin
      step();
      guard++;
    end
    tests++;
    if (guard >= FRAME) begin
      fails++;
      $display("FAIL midframe_reach: waited %0d cycles expected fewer than %0d", guard, FRAME);
    end
    rst = 1'b1;
    step();
    act = {r, g, b, hs, vs, blank, vclk, sync, bus.frame_done, bus.rd_addr};
    tests++;
    if (act !== {30'd0, 6'b110000, 15'd0}) begin
      fails++;
      $display("FAIL midframe_reset_state: got %h expected %h", act, {30'd0, 6'b110000, 15'd0});
    end
    rst = 1'b0;
    k = 0;
    while (k < FRAME && bus.frame_done !== 1'b1) begin
      step();
      k++;
    end
    tests++;
    if (k != 2 * VV * HT) begin
      fails++;
      $display("FAIL restart_frame_done: %0d cycles expected %0d", k, 2 * VV * HT);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached before summary", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n = 0;
    exp_addr = '0;
    test_reset();
    test_first_addr();
    test_sample_pixel();
    test_full_frame();
`ifdef SCANOUT_BORDER_EN
    test_border();
`endif
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
